// File: rtl/uart_boot_loader_if.sv
// Program-load port bundle: UART byte stream in, (addr, data, done) pair out to the CPU.
interface uart_boot_loader_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        skip_load;
  logic [31:0] uart_data;
  logic [31:0] uart_addr;
  logic        uart_done;
  logic [15:0] word_cnt;
  logic        load_err;

  modport master (
    output rx_byte, rx_valid, skip_load,
    input  uart_data, uart_addr, uart_done, word_cnt, load_err
  );

  modport slave (
    input  rx_byte, rx_valid, skip_load,
    output uart_data, uart_addr, uart_done, word_cnt, load_err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Assembles a little-endian word-count header plus payload words from the UART byte
// stream and presents each finished word as an atomic (addr, data) pair to the CPU loader.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_boot_loader_if.slave  bus
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_bidx;
  logic [31:0] r_shadow;
  logic [31:0] r_total;
  logic [15:0] r_widx;
  logic [31:0] r_idle;
  logic        r_started;
  logic [31:0] r_data;
  logic [31:0] r_addr;
  logic [15:0] r_cnt;

  logic        w_active;
  logic        w_timeout;
  logic [31:0] w_merged;
  logic [31:0] w_offs;
  logic [15:0] w_widx_nx;

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction

  assign w_active  = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_merged  = merge_byte(r_shadow, r_bidx, bus.rx_byte);
  assign w_offs    = 32'(ADDR_STEP) * {16'd0, r_widx};
  assign w_widx_nx = r_widx + 16'd1;
  // The idle counter is only armed once the session's first byte has arrived.
  assign w_timeout = w_active && r_started && !bus.rx_valid && (r_idle == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HDR;
      r_bidx    <= 2'd0;
      r_widx    <= 16'd0;
      r_idle    <= 32'd0;
      r_started <= 1'b0;
      r_data    <= 32'd0;
      r_addr    <= BASE_ADDR;
      r_cnt     <= 16'd0;
    end else if (w_active) begin
      if (bus.skip_load) begin
        r_state <= S_DONE;
      end else if (bus.rx_valid) begin
        r_started <= 1'b1;
        r_idle    <= 32'd0;
        r_shadow  <= w_merged;
        r_bidx    <= r_bidx + 2'd1;
        if (r_bidx == 2'd3) begin
          if (r_state == S_HDR) begin
            r_total <= w_merged;
            if (w_merged == 32'd0)                r_state <= S_DONE;
            else if (w_merged > 32'(MAX_WORDS))   r_state <= S_ERR;
            else                                  r_state <= S_DATA;
          end else begin
            // Data and address move together so the memory never sees a torn pair.
            r_data <= w_merged;
            r_addr <= BASE_ADDR + w_offs;
            r_cnt  <= w_widx_nx;
            r_widx <= w_widx_nx;
            if ({16'd0, w_widx_nx} == r_total) r_state <= S_LAST;
          end
        end
      end else if (w_timeout) begin
        r_state <= S_ERR;
      end else if (r_started) begin
        r_idle <= r_idle + 32'd1;
      end
    end else if (r_state == S_LAST) begin
      // One settling cycle so the final pair is written before the CPU leaves reset.
      r_state <= S_DONE;
    end
  end

  assign bus.uart_data = r_data;
  assign bus.uart_addr = r_addr;
  assign bus.uart_done = (r_state == S_DONE);
  assign bus.word_cnt  = r_cnt;
  assign bus.load_err  = (r_state == S_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: header/payload loads, empty and oversize headers,
// timeout, skip_load priority and mid-session reset.
module tb_uart_boot_loader;
  localparam int unsigned TO = 20;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_boot_loader_if bus ();

  uart_boot_loader #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_STEP (4),
    .MAX_WORDS (16384),
    .TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  // Four bytes on consecutive cycles with rx_valid held high throughout.
  task automatic send_word_bb(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus.rx_byte  = w[8*i +: 8];
      bus.rx_valid = 1'b1;
      tick(1);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.skip_load = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [15:0] cnt, input logic done, input logic err);
    check({tag, "_addr"}, bus.uart_addr, addr);
    check({tag, "_data"}, bus.uart_data, data);
    check({tag, "_cnt"},  {16'd0, bus.word_cnt}, {16'd0, cnt});
    check({tag, "_done"}, {31'd0, bus.uart_done}, {31'd0, done});
    check({tag, "_err"},  {31'd0, bus.load_err}, {31'd0, err});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;

    // Reset values
    do_reset();
    check_state("rst", 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);

    // Test 1: two-word load with gaps between bytes
    send_byte(8'h02); tick(1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_state("t1_hdr", 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    send_byte(8'h13); send_byte(8'h00); tick(3); send_byte(8'h00); send_byte(8'h00);
    check_state("t1_w0", 32'h0, 32'h0000_0013, 16'd1, 1'b0, 1'b0);
    send_byte(8'hB3); send_byte(8'h05); send_byte(8'h10);
    check_state("t1_hold", 32'h0, 32'h0000_0013, 16'd1, 1'b0, 1'b0);
    send_byte(8'h00);
    check_state("t1_w1", 32'h4, 32'h0010_05B3, 16'd2, 1'b0, 1'b0);
    tick(1);
    check_state("t1_done", 32'h4, 32'h0010_05B3, 16'd2, 1'b1, 1'b0);
    send_word_bb(32'hFFFF_FFFF);
    check_state("t1_ign", 32'h4, 32'h0010_05B3, 16'd2, 1'b1, 1'b0);

    // Test 2: zero-length header finishes immediately
    do_reset();
    send_word_bb(32'h0000_0000);
    check_state("t2", 32'h0, 32'h0, 16'd0, 1'b1, 1'b0);

    // Test 3: 16385-word header is rejected and later bytes are ignored
    do_reset();
    send_word_bb(32'h0000_4001);
    check_state("t3_err", 32'h0, 32'h0, 16'd0, 1'b0, 1'b1);
    send_word_bb(32'h0000_0001);
    send_word_bb(32'hDEAD_BEEF);
    check_state("t3_ign", 32'h0, 32'h0, 16'd0, 1'b0, 1'b1);

    // Test 3b: exactly MAX_WORDS is accepted
    do_reset();
    send_word_bb(32'h0000_4000);
    check_state("t3b", 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);

    // Test 4: timeout after a partial word
    do_reset();
    tick(3 * TO);
    check_state("t4_prewait", 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    send_word_bb(32'h0000_0003);
    send_word_bb(32'hDDCC_BBAA);
    send_byte(8'h11); send_byte(8'h22);
    tick(TO - 5);
    check_state("t4_early", 32'h0, 32'hDDCC_BBAA, 16'd1, 1'b0, 1'b0);
    tick(10);
    check_state("t4_to", 32'h0, 32'hDDCC_BBAA, 16'd1, 1'b0, 1'b1);

    // Test 5: skip_load beats a simultaneous final-byte strobe
    do_reset();
    send_word_bb(32'h0000_0002);
    send_word_bb(32'h0403_0201);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    bus.skip_load = 1'b1;
    send_byte(8'hA4);
    bus.skip_load = 1'b0;
    check_state("t5", 32'h0, 32'h0403_0201, 16'd1, 1'b1, 1'b0);

    // Test 6: reset mid-word, then a fresh back-to-back load
    do_reset();
    send_word_bb(32'h0000_0002);
    send_word_bb(32'h0403_0201);
    send_byte(8'h55); send_byte(8'h66);
    do_reset();
    check_state("t6_rst", 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    send_word_bb(32'h0000_0001);
    send_word_bb(32'h1234_5678);
    check_state("t6_w0", 32'h0, 32'h1234_5678, 16'd1, 1'b0, 1'b0);
    tick(1);
    check_state("t6_done", 32'h0, 32'h1234_5678, 16'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
